serial_adder_ctrl: RTL

// - Bit-serial add/subtract engine: sequences one 1-bit full adder (module adder) over WIDTH-bit operands,
//   one bit per clock, LSB first, with a registered carry between bits.
// - Sits between the ALU front-end (valid/ready operand source) and the result consumer.
// - Area-cheap alternative to the parallel 74181-style path.

---
 rtl/serial_alu_pkg.sv | 15 +
 rtl/serial_adder_ctrl_if.sv | 32 +++
 rtl/adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial add/subtract controller.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } ser_op_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle between the ALU front-end, the serial engine and the consumer.
interface serial_adder_ctrl_if
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  ser_op_t          op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;
  logic             busy;

  // Operand source plus result consumer side
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum, carry, ovf, busy
  );

  // Serial engine side
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum, carry, ovf, busy
  );

endinterface

// File: rtl/adder.sv
// One-bit full adder; the only arithmetic in the serial engine.
module adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full adder stepped LSB-first over WIDTH bits.
module serial_adder_ctrl
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry_q;
  logic [IDX_W-1:0] r_bit_idx;
  logic             r_cin_msb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_in;
  logic             w_s;
  logic             w_c_out;

  // Handshake decode; subtraction feeds the inverted B operand with carry-in of 1
  always_comb begin
    w_in_ready = 1'b0;
    w_accept   = 1'b0;
    w_b_in     = bus.b;
    w_in_ready = (r_state == IDLE) | ((r_state == DONE) & bus.out_ready);
    w_accept   = bus.in_valid & w_in_ready;
    if (bus.op == OP_SUB) begin
      w_b_in = ~bus.b;
    end
  end

  adder u_fa (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .c_in  (r_carry_q),
    .s     (w_s),
    .c_out (w_c_out)
  );

  // Controller state, operand shifters and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_carry_q   <= 1'b0;
      r_bit_idx   <= '0;
      r_cin_msb   <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_a_sh      <= bus.a;
            r_b_sh      <= w_b_in;
            r_carry_q   <= (bus.op == OP_SUB);
            r_bit_idx   <= '0;
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
          end else if ((r_state == DONE) && bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        RUN: begin
          r_sum     <= {w_s, r_sum[WIDTH-1:1]};
          r_carry_q <= w_c_out;
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          if (r_bit_idx == IDX_W'(WIDTH - 2)) begin
            r_cin_msb <= w_c_out;
          end
          if (r_bit_idx == IDX_W'(WIDTH - 1)) begin
            r_bit_idx   <= '0;
            r_carry     <= w_c_out;
            r_ovf       <= r_cin_msb ^ w_c_out;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_bit_idx <= r_bit_idx + IDX_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.carry     = r_carry;
  assign bus.ovf       = r_ovf;
  assign bus.busy      = r_busy;

endmodule
